// File: rtl/gpu_noc_ni_bridge_if.sv
// rtl/gpu_noc_ni_bridge_if.sv - GPU-side and router-side valid/ready channels of the NI bridge
interface gpu_noc_ni_bridge_if #(
    parameter int ID_W      = 6,
    parameter int PAYLOAD_W = 10
);
    localparam int FW = ID_W + PAYLOAD_W;
    localparam int NW = 2 * ID_W + PAYLOAD_W;

    logic [FW-1:0] gpu_data_in;
    logic          gpu_valid_in;
    logic          gpu_ready_out;
    logic [FW-1:0] gpu_data_out;
    logic          gpu_valid_out;
    logic          gpu_ready_in;
    logic [NW-1:0] noc_flit_out;
    logic          noc_valid_out;
    logic          noc_ready_in;
    logic [NW-1:0] noc_flit_in;
    logic          noc_valid_in;
    logic          noc_ready_out;

    modport slave (
        input  gpu_data_in, gpu_valid_in, gpu_ready_in,
        input  noc_ready_in, noc_flit_in, noc_valid_in,
        output gpu_ready_out, gpu_data_out, gpu_valid_out,
        output noc_flit_out, noc_valid_out, noc_ready_out
    );

    modport master (
        output gpu_data_in, gpu_valid_in, gpu_ready_in,
        output noc_ready_in, noc_flit_in, noc_valid_in,
        input  gpu_ready_out, gpu_data_out, gpu_valid_out,
        input  noc_flit_out, noc_valid_out, noc_ready_out
    );
endinterface

// File: rtl/gpu_noc_ni_bridge.sv
// rtl/gpu_noc_ni_bridge.sv - GPU tile to NoC network-interface bridge with egress/ingress FIFOs
// Optional flit statistics counters are built when NI_STATS_EN is defined.
module gpu_noc_ni_bridge #(
    parameter int              ID_W      = 6,
    parameter int              PAYLOAD_W = 10,
    parameter int              DEPTH     = 4,
    parameter logic [ID_W-1:0] LOCAL_ID  = ID_W'(10),
    parameter logic [ID_W-1:0] BCAST_ID  = {ID_W{1'b1}}
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    gpu_noc_ni_bridge_if.slave    ni,
    output logic                  ovf_err,
    output logic [15:0]           tx_count,
    output logic [15:0]           rx_count,
    output logic [15:0]           drop_count
);
    localparam int FW = ID_W + PAYLOAD_W;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // ---------------- egress ----------------
    logic [FW-1:0] eg_mem [DEPTH];
    logic [AW-1:0] eg_wr, eg_rd;
    logic [AW:0]   eg_cnt;
    logic          eg_full, eg_empty, eg_push, eg_pop;

    assign eg_full  = (eg_cnt == FULL_CNT);
    assign eg_empty = (eg_cnt == '0);
    // A full FIFO refuses the push even when it is draining this same cycle.
    assign eg_push  = ni.gpu_valid_in && !eg_full;
    assign eg_pop   = !eg_empty && ni.noc_ready_in;

    assign ni.gpu_ready_out = !eg_full;
    assign ni.noc_valid_out = !eg_empty;
    assign ni.noc_flit_out  = {LOCAL_ID, eg_mem[eg_rd]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            eg_wr   <= '0;
            eg_rd   <= '0;
            eg_cnt  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (eg_push) eg_wr <= eg_wr + AW'(1);
            if (eg_pop)  eg_rd <= eg_rd + AW'(1);
            case ({eg_push, eg_pop})
                2'b10:   eg_cnt <= eg_cnt + (AW+1)'(1);
                2'b01:   eg_cnt <= eg_cnt - (AW+1)'(1);
                default: eg_cnt <= eg_cnt;
            endcase
            if (ni.gpu_valid_in && eg_full) ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (eg_push) eg_mem[eg_wr] <= ni.gpu_data_in;
    end

    // ---------------- ingress ----------------
    logic [FW-1:0]   in_mem [DEPTH];
    logic [AW-1:0]   in_wr, in_rd;
    logic [AW:0]     in_cnt;
    logic            in_full, in_empty, in_acc, in_match, in_push, in_pop;
    logic [ID_W-1:0] in_dest;
    logic            unused_src;

    assign in_dest  = ni.noc_flit_in[PAYLOAD_W +: ID_W];
    // Source ID is stripped and never influences filtering, so self-loop flits match normally.
    assign unused_src = &{1'b0, ni.noc_flit_in[FW +: ID_W]};

    assign in_full  = (in_cnt == FULL_CNT);
    assign in_empty = (in_cnt == '0);
    assign in_acc   = ni.noc_valid_in && !in_full;
    assign in_match = (in_dest == LOCAL_ID) || (in_dest == BCAST_ID);
    assign in_push  = in_acc && in_match;
    assign in_pop   = !in_empty && ni.gpu_ready_in;

    assign ni.noc_ready_out = !in_full;
    assign ni.gpu_valid_out = !in_empty;
    assign ni.gpu_data_out  = in_mem[in_rd];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + AW'(1);
            if (in_pop)  in_rd <= in_rd + AW'(1);
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + (AW+1)'(1);
                2'b01:   in_cnt <= in_cnt - (AW+1)'(1);
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (in_push) in_mem[in_wr] <= ni.noc_flit_in[FW-1:0];
    end

    // ---------------- statistics ----------------
`ifdef NI_STATS_EN
    logic in_drop;
    assign in_drop = in_acc && !in_match;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tx_count   <= 16'h0;
            rx_count   <= 16'h0;
            drop_count <= 16'h0;
        end else begin
            if (eg_pop  && tx_count   != 16'hFFFF) tx_count   <= tx_count   + 16'd1;
            if (in_pop  && rx_count   != 16'hFFFF) rx_count   <= rx_count   + 16'd1;
            if (in_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign tx_count   = 16'h0;
    assign rx_count   = 16'h0;
    assign drop_count = 16'h0;
`endif
endmodule
